alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have ports instr_valid (input, 1) and instr[31:0] (input, 32), which present an instruction; instr_ready (output, 1) accepts it.
REQ-004 SHALL have ports rf_rs_addr and rf_rt_addr (outputs, 5 each) and rf_rs_data and rf_rt_data (inputs, 32 each); read data is valid one cycle after the address.
REQ-005 SHALL have ports alu_op (output, 6), alu_a (output, 32) and alu_b (output, 32), driving the ALU.
REQ-006 SHALL have ports alu_out (input, 32), alu_mulout (input, 64) and alu_carry, alu_zero, alu_sign, alu_ovf (inputs, 1 each), carrying combinational ALU results.
REQ-007 SHALL have ports rf_we (output, 1), rf_wa (output, 5) and rf_wd (output, 32), the register-file write port.
REQ-008 SHALL have ports flags[3:0] (output, 4) = {carry, zero, sign, ovf}, done (output, 1) and illegal (output, 1).

Function
REQ-009 SHALL decode instr[31:26] as the ALU opcode, instr[25:21] as rs, instr[20:16] as rt, and instr[15:0] as imm16.
REQ-010 SHALL classify opcodes as follows: R-type add 000000 and and 000110; I-type addi 000001, compi 000101, shrl 001001 and shra 001100; M-type mult 000010 and multu 000011; every other opcode is illegal.
REQ-011 SHALL implement FSM states IDLE, READ, EXEC, WB and WB2; reset enters IDLE.
REQ-012 SHALL assert instr_ready only in IDLE; a handshake (valid & ready) latches instr and moves to READ.
REQ-013 READ SHALL drive rf_rs_addr=rs and rf_rt_addr=rt, then go to EXEC; an illegal opcode instead pulses illegal for one cycle and returns to IDLE with no write.
REQ-014 EXEC SHALL drive alu_op=opcode and alu_a=rs data; alu_b SHALL be rt data for R/M-type and sign-extended imm16 for I-type.
REQ-015 EXEC SHALL register alu_out, alu_mulout and all four flags; flags SHALL update for every legal op and hold otherwise.
REQ-016 WB SHALL write the result to rs (R/I-type) or the low product word to rs (M-type).
REQ-017 WB2 (M-type only) SHALL write the high product word to rt.
REQ-018 SHALL pulse done for one cycle on the final writeback cycle, then return to IDLE.
REQ-019 Latency: a handshake in cycle 0 SHALL produce the WB write in cycle 3 (WB2 in cycle 4); the next instr_ready SHALL assert in cycle 4 (cycle 5 for M-type).
REQ-020 Writes to address 0 SHALL keep rf_we low; done SHALL still pulse.
REQ-021 alu_op, alu_a and alu_b SHALL be 0 outside EXEC.
REQ-022 instr_valid dropping outside IDLE SHALL have no effect; a new instr SHALL NOT be sampled mid-operation.

Reset
REQ-023 rst SHALL force IDLE, with instr_ready=1 and rf_we, rf_wa, rf_wd, flags, done, illegal and all ALU drive outputs = 0, in the next cycle.
REQ-024 rst in any state, including WB2, SHALL abort the operation with no further write.

Structure
REQ-025 Opcode constants, the type-class encoding and the FSM state encoding SHALL live in a shared package kgp_risc_pkg.
REQ-026 Decode (opcode -> class/legal) SHALL be a combinational sub-module alu_op_decode; the FSM, latches and writeback SHALL stay in alu_issue_ctrl.

Verification
REQ-027 addi, rs=3 (value 0), imm=7 -> cycle 3: rf_we=1, rf_wa=3, rf_wd=0x00000007, done=1, flags zero=0.
REQ-028 add, rs=0x0000008B, rt=0xFFFFFFFF -> rf_wd=0x0000008A, flags carry=1.
REQ-029 mult, rs=120, rt=0xFFFFFFF6 -> WB rs<=0xFFFFFB50, WB2 rt<=0xFFFFFFFF; multu with the same operands -> rs<=0xFFFFFB50, rt<=0x00000077.
REQ-030 Opcode 111111 -> illegal pulse in cycle 1, no rf_we, instr_ready high in cycle 2.
REQ-031 rst asserted during EXEC of mult -> no write in the following cycles, IDLE and instr_ready=1, flags=0.
REQ-032 Write with rs=0 -> rf_we stays 0, done pulses; back-to-back valid -> second instr accepted only in cycle 4.

Source files
------------

// File: rtl/kgp_risc_pkg.sv
// kgp_risc_pkg: shared opcode constants, instruction class encoding and the
// issue-controller FSM state encoding.
package kgp_risc_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000001;
  localparam logic [5:0] OP_MULT  = 6'b000010;
  localparam logic [5:0] OP_MULTU = 6'b000011;
  localparam logic [5:0] OP_COMPI = 6'b000101;
  localparam logic [5:0] OP_AND   = 6'b000110;
  localparam logic [5:0] OP_SHRL  = 6'b001001;
  localparam logic [5:0] OP_SHRA  = 6'b001100;

  typedef enum logic [1:0] {
    CLS_R   = 2'd0,
    CLS_I   = 2'd1,
    CLS_M   = 2'd2,
    CLS_ILL = 2'd3
  } op_class_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_WB   = 3'd3,
    S_WB2  = 3'd4
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational opcode classifier.
//   opcode   : instruction bits [31:26]
//   op_class : R / I / M type, or CLS_ILL for unknown opcodes
//   legal    : 1 when the opcode is one of the supported operations
module alu_op_decode
  import kgp_risc_pkg::*;
(
  input  logic [5:0] opcode,
  output op_class_e  op_class,
  output logic       legal
);

  always_comb begin
    op_class = CLS_ILL;
    legal    = 1'b1;
    unique case (opcode)
      OP_ADD, OP_AND:                       op_class = CLS_R;
      OP_ADDI, OP_COMPI, OP_SHRL, OP_SHRA:  op_class = CLS_I;
      OP_MULT, OP_MULTU:                    op_class = CLS_M;
      default: begin
        op_class = CLS_ILL;
        legal    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: single-issue controller that accepts one instruction,
// reads its operands, drives the external ALU, and writes the result back.
//   clk, rst                  : clock, synchronous active-high reset
//   instr_valid/instr/ready   : instruction handshake (ready only in IDLE)
//   rf_rs_addr/rf_rt_addr     : register-file read addresses (data next cycle)
//   rf_rs_data/rf_rt_data     : register-file read data
//   alu_op/alu_a/alu_b        : ALU drive, non-zero only in EXEC
//   alu_out/alu_mulout/flags  : combinational ALU results
//   rf_we/rf_wa/rf_wd         : register-file write port
//   flags                     : registered {carry, zero, sign, ovf}
//   done, illegal             : completion / illegal-opcode pulses
module alu_issue_ctrl
  import kgp_risc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [4:0]  rf_rs_addr,
  output logic [4:0]  rf_rt_addr,
  input  logic [31:0] rf_rs_data,
  input  logic [31:0] rf_rt_data,
  output logic [5:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_out,
  input  logic [63:0] alu_mulout,
  input  logic        alu_carry,
  input  logic        alu_zero,
  input  logic        alu_sign,
  input  logic        alu_ovf,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic [3:0]  flags,
  output logic        done,
  output logic        illegal
);

  state_e      state_q, state_d;
  logic [31:0] instr_q;
  logic [31:0] res_lo_q, res_hi_q;
  logic [3:0]  flags_q;
  op_class_e   op_class;
  logic        legal;

  logic [5:0]  opcode;
  logic [4:0]  rs, rt;
  logic [15:0] imm16;

  assign opcode = instr_q[31:26];
  assign rs     = instr_q[25:21];
  assign rt     = instr_q[20:16];
  assign imm16  = instr_q[15:0];
  assign flags  = flags_q;

  alu_op_decode u_decode (
    .opcode   (opcode),
    .op_class (op_class),
    .legal    (legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && instr_valid)
        instr_q <= instr;
      // Only legal ops reach EXEC, so flags hold across illegal ones.
      if (state_q == S_EXEC) begin
        flags_q  <= {alu_carry, alu_zero, alu_sign, alu_ovf};
        res_lo_q <= (op_class == CLS_M) ? alu_mulout[31:0] : alu_out;
        res_hi_q <= alu_mulout[63:32];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    rf_rs_addr  = '0;
    rf_rt_addr  = '0;
    alu_op      = '0;
    alu_a       = '0;
    alu_b       = '0;
    rf_we       = 1'b0;
    rf_wa       = '0;
    rf_wd       = '0;
    done        = 1'b0;
    illegal     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = S_READ;
      end
      S_READ: begin
        rf_rs_addr = rs;
        rf_rt_addr = rt;
        if (!legal) begin
          illegal = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_op  = opcode;
        alu_a   = rf_rs_data;
        alu_b   = (op_class == CLS_I) ? {{16{imm16[15]}}, imm16} : rf_rt_data;
        state_d = S_WB;
      end
      S_WB: begin
        rf_wa = rs;
        rf_wd = res_lo_q;
        rf_we = (rs != '0);
        if (op_class == CLS_M) begin
          state_d = S_WB2;
        end else begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WB2: begin
        rf_wa   = rt;
        rf_wd   = res_hi_q;
        rf_we   = (rt != '0);
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A reset arriving during a writeback state aborts that write immediately.
    if (rst) begin
      rf_we = 1'b0;
      done  = 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  import kgp_risc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [4:0]  rf_rs_addr, rf_rt_addr;
  logic [31:0] rf_rs_data, rf_rt_data;
  logic [5:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_out;
  logic [63:0] alu_mulout;
  logic        alu_carry, alu_zero, alu_sign, alu_ovf;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [3:0]  flags;
  logic        done, illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .rf_rs_addr(rf_rs_addr), .rf_rt_addr(rf_rt_addr),
    .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_mulout(alu_mulout),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_sign(alu_sign),
    .alu_ovf(alu_ovf), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .flags(flags), .done(done), .illegal(illegal)
  );

  // Behavioural ALU environment.
  logic [32:0] sum33;
  logic [63:0] sx_a, sx_b;
  always_comb begin
    sum33      = {1'b0, alu_a} + {1'b0, alu_b};
    sx_a       = {{32{alu_a[31]}}, alu_a};
    sx_b       = {{32{alu_b[31]}}, alu_b};
    alu_out    = '0;
    alu_mulout = '0;
    alu_carry  = 1'b0;
    alu_ovf    = 1'b0;
    case (alu_op)
      OP_ADD, OP_ADDI: begin
        alu_out   = sum33[31:0];
        alu_carry = sum33[32];
        alu_ovf   = (alu_a[31] == alu_b[31]) && (sum33[31] != alu_a[31]);
      end
      OP_AND:   alu_out = alu_a & alu_b;
      OP_COMPI: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      OP_SHRL:  alu_out = alu_a >> alu_b[4:0];
      OP_SHRA:  alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      OP_MULT: begin
        alu_mulout = sx_a * sx_b;
        alu_out    = alu_mulout[31:0];
      end
      OP_MULTU: begin
        alu_mulout = {32'd0, alu_a} * {32'd0, alu_b};
        alu_out    = alu_mulout[31:0];
      end
      default: alu_out = '0;
    endcase
    alu_zero = (alu_out == 32'd0);
    alu_sign = alu_out[31];
  end

  // Register-file model with a preload port for the bench.
  logic [31:0] regs [32];
  logic        rf_clr, pl_en;
  logic [4:0]  pl_a;
  logic [31:0] pl_d;
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      if (pl_en) regs[pl_a] <= pl_d;
      if (rf_we === 1'b1) regs[rf_wa] <= rf_wd;
    end
    rf_rs_data <= regs[rf_rs_addr];
    rf_rt_data <= regs[rf_rt_addr];
  end

  // Scoreboard of expected register-file writes.
  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] wd;
  } wr_t;
  wr_t exp_q[$];

  always @(negedge clk) begin
    wr_t e;
    if (rf_we === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_write: got wa=%0d wd=%h, expected no write", rf_wa, rf_wd);
      end else begin
        e = exp_q.pop_front();
        if (rf_wa !== e.wa || rf_wd !== e.wd) begin
          bad++;
          $display("FAIL sb_write: got wa=%0d wd=%h, expected wa=%0d wd=%h",
                   rf_wa, rf_wd, e.wa, e.wd);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reg(input logic [4:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [15:0] imm,
                        input logic [31:0] exp_a, input logic [31:0] exp_b,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                        input logic mtype, input logic [3:0] exp_flags);
    if (rs != 5'd0) exp_q.push_back('{wa: rs, wd: exp_lo});
    if (mtype && rt != 5'd0) exp_q.push_back('{wa: rt, wd: exp_hi});
    instr = {op, rs, rt, imm};
    instr_valid = 1'b1;
    total++;
    if (instr_ready !== 1'b1) begin
      bad++; $display("FAIL %s_ready_c0: got %b, expected 1", nm, instr_ready);
    end
    tick();
    instr_valid = 1'b0;
    total++;
    if (rf_rs_addr !== rs || rf_rt_addr !== rt || illegal !== 1'b0) begin
      bad++;
      $display("FAIL %s_read_c1: got rs=%0d rt=%0d ill=%b, expected rs=%0d rt=%0d ill=0",
               nm, rf_rs_addr, rf_rt_addr, illegal, rs, rt);
    end
    tick();
    total++;
    if (alu_op !== op || alu_a !== exp_a || alu_b !== exp_b) begin
      bad++;
      $display("FAIL %s_exec_c2: got op=%h a=%h b=%h, expected op=%h a=%h b=%h",
               nm, alu_op, alu_a, alu_b, op, exp_a, exp_b);
    end
    tick();
    total++;
    if (alu_op !== 6'd0 || alu_a !== 32'd0 || alu_b !== 32'd0 ||
        rf_we !== (rs != 5'd0) || done !== !mtype || instr_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s_wb_c3: got op=%h a=%h b=%h we=%b done=%b rdy=%b, expected alu=0 we=%b done=%b rdy=0",
               nm, alu_op, alu_a, alu_b, rf_we, done, instr_ready, (rs != 5'd0), !mtype);
    end
    tick();
    total++;
    if (flags !== exp_flags) begin
      bad++; $display("FAIL %s_flags: got %b, expected %b", nm, flags, exp_flags);
    end
    if (mtype) begin
      total++;
      if (done !== 1'b1 || rf_we !== (rt != 5'd0) || instr_ready !== 1'b0) begin
        bad++;
        $display("FAIL %s_wb2_c4: got done=%b we=%b rdy=%b, expected done=1 we=%b rdy=0",
                 nm, done, rf_we, instr_ready, (rt != 5'd0));
      end
      tick();
    end
    total++;
    if (instr_ready !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL %s_ready_after: got rdy=%b done=%b, expected rdy=1 done=0",
                      nm, instr_ready, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rf_clr = 1'b1; instr_valid = 1'b0; instr = '0;
    pl_en = 1'b0; pl_a = '0; pl_d = '0;
    tick(); tick();
    total++;
    if (instr_ready !== 1'b1 || rf_we !== 1'b0 || rf_wa !== 5'd0 || rf_wd !== 32'd0 ||
        flags !== 4'd0 || done !== 1'b0 || illegal !== 1'b0 ||
        alu_op !== 6'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
      bad++;
      $display("FAIL reset_state: got rdy=%b we=%b wa=%0d wd=%h fl=%b done=%b ill=%b op=%h a=%h b=%h, expected rdy=1 all else 0",
               instr_ready, rf_we, rf_wa, rf_wd, flags, done, illegal, alu_op, alu_a, alu_b);
    end
    rst = 1'b0; rf_clr = 1'b0;
    tick();
  endtask

  task automatic test_arith();
    run_op("addi", OP_ADDI, 5'd3, 5'd0, 16'd7, 32'd0, 32'd7, 32'h7, 32'h0, 1'b0, 4'b0000);
    set_reg(5'd1, 32'h0000008B);
    set_reg(5'd2, 32'hFFFFFFFF);
    run_op("add", OP_ADD, 5'd1, 5'd2, 16'd0, 32'h8B, 32'hFFFFFFFF,
           32'h0000008A, 32'h0, 1'b0, 4'b1000);
  endtask

  task automatic test_mult();
    set_reg(5'd4, 32'd120);
    set_reg(5'd5, 32'hFFFFFFF6);
    run_op("mult", OP_MULT, 5'd4, 5'd5, 16'd0, 32'd120, 32'hFFFFFFF6,
           32'hFFFFFB50, 32'hFFFFFFFF, 1'b1, 4'b0010);
    set_reg(5'd4, 32'd120);
    set_reg(5'd5, 32'hFFFFFFF6);
    run_op("multu", OP_MULTU, 5'd4, 5'd5, 16'd0, 32'd120, 32'hFFFFFFF6,
           32'hFFFFFB50, 32'h00000077, 1'b1, 4'b0010);
  endtask

  task automatic test_illegal();
    instr = {6'b111111, 5'd3, 5'd4, 16'h1234};
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    total++;
    if (illegal !== 1'b1 || rf_we !== 1'b0 || instr_ready !== 1'b0) begin
      bad++; $display("FAIL illegal_c1: got ill=%b we=%b rdy=%b, expected ill=1 we=0 rdy=0",
                      illegal, rf_we, instr_ready);
    end
    tick();
    total++;
    if (instr_ready !== 1'b1 || illegal !== 1'b0 || flags !== 4'b0010) begin
      bad++; $display("FAIL illegal_c2: got rdy=%b ill=%b fl=%b, expected rdy=1 ill=0 fl=0010",
                      instr_ready, illegal, flags);
    end
  endtask

  task automatic test_logic();
    set_reg(5'd7,  32'hF0F01234);
    set_reg(5'd8,  32'h0FF0FFFF);
    set_reg(5'd9,  32'h80000010);
    set_reg(5'd10, 32'hFFFFFFFF);
    set_reg(5'd11, 32'h80000000);
    run_op("and", OP_AND, 5'd7, 5'd8, 16'd0, 32'hF0F01234, 32'h0FF0FFFF,
           32'h00F01234, 32'h0, 1'b0, 4'b0000);
    run_op("shra", OP_SHRA, 5'd9, 5'd0, 16'd4, 32'h80000010, 32'd4,
           32'hF8000001, 32'h0, 1'b0, 4'b0010);
    run_op("compi", OP_COMPI, 5'd10, 5'd0, 16'hFFFE, 32'hFFFFFFFF, 32'hFFFFFFFE,
           32'h0, 32'h0, 1'b0, 4'b0100);
    run_op("shrl", OP_SHRL, 5'd11, 5'd0, 16'd31, 32'h80000000, 32'd31,
           32'h1, 32'h0, 1'b0, 4'b0000);
  endtask

  task automatic test_zero_reg();
    run_op("r0_write", OP_ADDI, 5'd0, 5'd0, 16'd5, 32'd0, 32'd5, 32'd5, 32'h0, 1'b0, 4'b0000);
  endtask

  task automatic test_back_to_back();
    exp_q.push_back('{wa: 5'd14, wd: 32'd1});
    exp_q.push_back('{wa: 5'd15, wd: 32'd2});
    instr = {OP_ADDI, 5'd14, 5'd0, 16'd1};
    instr_valid = 1'b1;
    tick();
    instr = {OP_ADDI, 5'd15, 5'd0, 16'd2};
    for (int c = 1; c <= 3; c++) begin
      total++;
      if (instr_ready !== 1'b0) begin
        bad++; $display("FAIL b2b_busy_c%0d: got rdy=%b, expected 0", c, instr_ready);
      end
      tick();
    end
    total++;
    if (instr_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_accept_c4: got rdy=%b, expected 1", instr_ready);
    end
    tick();
    instr_valid = 1'b0;
    total++;
    if (rf_rs_addr !== 5'd15) begin
      bad++; $display("FAIL b2b_second_read: got rs=%0d, expected 15", rf_rs_addr);
    end
    tick(); tick();
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL b2b_second_done: got done=%b, expected 1", done);
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    set_reg(5'd12, 32'd3);
    set_reg(5'd13, 32'd4);
    instr = {OP_MULT, 5'd12, 5'd13, 16'd0};
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    rst = 1'b1;
    total++;
    if (alu_op !== OP_MULT) begin
      bad++; $display("FAIL rstmid_exec: got op=%h, expected %h", alu_op, OP_MULT);
    end
    tick();
    rst = 1'b0;
    total++;
    if (instr_ready !== 1'b1 || flags !== 4'd0 || rf_we !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL rstmid_idle: got rdy=%b fl=%b we=%b done=%b, expected rdy=1 fl=0 we=0 done=0",
                      instr_ready, flags, rf_we, done);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      total++;
      if (rf_we !== 1'b0 || done !== 1'b0) begin
        bad++; $display("FAIL rstmid_quiet_%0d: got we=%b done=%b, expected 0 0", c, rf_we, done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_mult();
    test_illegal();
    test_logic();
    test_zero_reg();
    test_back_to_back();
    test_reset_mid_op();
    tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL sb_drain: got %0d pending writes, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
